// File: rtl/clock_gate_pkg.sv
// rtl/clock_gate_pkg.sv - shared types and helpers for the clock-gate enable controller
//
// Contents:
//   state_t       - controller state encoding (RUN, DRAIN, GATED, WAKE)
//   calc_cnt_w    - width of the shared countdown for given idle/wake lengths
//   params_ok     - legality check for the idle/wake parameters
package clock_gate_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    // Counter must hold max(IDLE_CYCLES, WAKE_CYCLES)-1; sizing for max+1
    // keeps a spare code and never yields a zero width.
    function automatic int calc_cnt_w(input int idle_cycles, input int wake_cycles);
        int m;
        m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

    function automatic bit params_ok(input int idle_cycles, input int wake_cycles);
        return (idle_cycles >= 1) && (wake_cycles >= 1);
    endfunction

endpackage

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - enable controller for one integrated clock-gating cell
//
// Runs on the ungated clock. Gates the sub-domain after an idle window and
// restores it on wake, holding off ready until the clock has settled.
//
// Ports:
//   clock            in   ungated clock, all state on rising edge
//   reset            in   synchronous, active-high
//   io_busy          in   gated domain has work in flight
//   io_wake          in   upstream has work for the gated domain
//   io_allow         in   power policy permits gating
//   io_gate_en       out  registered enable to the gating cell
//   io_ready         out  clock running and settled (RUN or DRAIN)
//   io_gated         out  state is GATED
//   io_err           out  sticky: busy observed while GATED
//   io_gated_cycles  out  wrapping count of cycles spent GATED
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = calc_cnt_w(IDLE_CYCLES, WAKE_CYCLES)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_busy,
    input  logic        io_wake,
    input  logic        io_allow,
    output logic        io_gate_en,
    output logic        io_ready,
    output logic        io_gated,
    output logic        io_err,
    output logic [31:0] io_gated_cycles
);

    if (!params_ok(IDLE_CYCLES, WAKE_CYCLES)) begin : g_param_check
        $error("clock_gate_ctrl: IDLE_CYCLES and WAKE_CYCLES must both be >= 1");
    end

    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic             gate_en_q;
    logic             err_q;
    logic [31:0]      gated_cnt_q;

    // Next-state and shared countdown. In DRAIN an abort condition wins over
    // expiry; WAKE ignores its inputs so a restored clock always settles fully.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (io_allow && !io_busy && !io_wake) begin
                    state_n = ST_DRAIN;
                    cnt_n   = IDLE_LOAD;
                end
            end
            ST_DRAIN: begin
                if (io_busy || io_wake || !io_allow) begin
                    state_n = ST_RUN;
                end else if (cnt_q == '0) begin
                    state_n = ST_GATED;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            ST_GATED: begin
                if (io_wake || !io_allow) begin
                    state_n = ST_WAKE;
                    cnt_n   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) begin
                    state_n = ST_RUN;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    // The enable is registered from next-state so it only moves just after a
    // rising edge, while the cell's latch is transparent-low and stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            gate_en_q   <= 1'b1;
            err_q       <= 1'b0;
            gated_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            gate_en_q <= (state_n != ST_GATED);
            if (state_q == ST_GATED) begin
                gated_cnt_q <= gated_cnt_q + 32'd1;
                if (io_busy) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign io_gate_en      = gate_en_q;
    assign io_ready        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign io_gated        = (state_q == ST_GATED);
    assign io_err          = err_q;
    assign io_gated_cycles = gated_cnt_q;

endmodule

// File: doc/clock_gate_ctrl.md
# clock_gate_ctrl

Sequential enable controller that drives the `en` input of the integrated clock-gating cell for one gated sub-domain. It watches domain activity and a permission signal, gates the clock after a programmable idle window, and restores it on wake with a settle delay before it reports ready. It sits directly upstream of the gating cell and runs on the ungated clock. `test_en` bypasses this block and goes straight to the cell.

## Interface
Parameters:
- `IDLE_CYCLES`, default 16: idle countdown length in cycles; must be ≥1.
- `WAKE_CYCLES`, default 2: settle cycles after clock restore before ready; must be ≥1.
- `CNT_W`, default derived as clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1): shared countdown width.

Ports:
- `clock` in 1: ungated clock; all state on its rising edge.
- `reset` in 1: synchronous, active-high.
- `io_busy` in 1: gated domain has work in flight.
- `io_wake` in 1: upstream has work for the gated domain.
- `io_allow` in 1: power policy permits gating.
- `io_gate_en` out 1: registered; connects to the gating cell `en`.
- `io_ready` out 1: clock is running and settled, so upstream may issue.
- `io_gated` out 1: state is GATED.
- `io_err` out 1: sticky; `io_busy` was seen while GATED.
- `io_gated_cycles` out 32: count of cycles spent in GATED; wraps.

## Operation
- States: RUN, DRAIN, GATED, WAKE. Reset state is RUN.
- Reset values: `io_gate_en`=1, `io_ready`=1, `io_gated`=0, `io_err`=0, `io_gated_cycles`=0, counter=0.
- RUN:
  - If `io_allow && !io_busy && !io_wake`, go to DRAIN and load the counter with IDLE_CYCLES-1.
- DRAIN:
  - If `io_busy || io_wake || !io_allow`, return to RUN. Abort has priority over expiry.
  - Else if counter==0, go to GATED.
  - Else decrement the counter.
- GATED:
  - If `io_wake || !io_allow`, go to WAKE and load the counter with WAKE_CYCLES-1.
  - If `io_busy` is seen, set `io_err`; the state does not change because of it.
- WAKE:
  - If counter==0, go to RUN; else decrement.
  - Not abortable: a wake that drops mid-WAKE still completes to RUN.
- Outputs:
  - `io_gate_en` is a register loaded with (next_state != GATED).
  - `io_ready` = state ∈ {RUN, DRAIN}, decoded from the state register.
  - `io_gated` = state==GATED.
  - `io_gated_cycles` increments every cycle state==GATED, wrapping from 2^32-1 to 0.
- `io_err` clears only on reset.

## Timing
- Gating latency:
  - First idle sample at edge t puts the block in DRAIN at t+1.
  - GATED and `io_gate_en`=0 follow at t+IDLE_CYCLES+1, given IDLE_CYCLES+1 consecutive qualifying samples.
- Wake latency: wake sampled in GATED at edge t gives `io_gate_en`=1 at t+1 and `io_ready`=1 at t+1+WAKE_CYCLES.
- Glitch safety: `io_gate_en` changes only just after a rising edge, so the cell's low-phase latch captures a stable value.
- Reset mid-operation (any state): RUN and `io_gate_en`=1 on the edge where reset is sampled.
- Wake and `!io_allow` arriving together in GATED: a single transition to WAKE.

## Structure
- Shared package `clock_gate_pkg`:
  - state enum (RUN=0, DRAIN=1, GATED=2, WAKE=3);
  - CNT_W derivation function;
  - elaboration-time parameter checks (IDLE_CYCLES≥1, WAKE_CYCLES≥1).
- Single flat module: one FSM, one shared down-counter, one 32-bit cycle counter, one sticky error flop. No sub-module.

## Test plan
- Reset, then `io_allow`=1 and `io_busy`=0 held. Required: `io_gate_en` falls exactly 17 edges after the first idle sample, `io_ready`=0, `io_gated`=1.
- In GATED, pulse `io_wake` for 1 cycle. Required: `io_gate_en`=1 the next edge, `io_ready`=1 three edges after the sample, state RUN.
- In DRAIN with the counter at 0, assert `io_busy` in the same cycle. Required: state RUN, `io_gate_en` stays 1, no GATED cycle counted.
- In GATED, deassert `io_allow`. Required: WAKE then RUN. Assert `io_busy` in GATED. Required: `io_err`=1, held until reset.
- Assert reset mid-WAKE and mid-GATED. Required: `io_gate_en`=1, `io_ready`=1, `io_err`=0, `io_gated_cycles`=0 after the reset edge.
- Hold GATED long, or force the counter to 0xFFFF_FFFE. Required: `io_gated_cycles` wraps to 0 with no state change.
